nd_1ton: RTL

ND_1TON -- requirements
Module: nd_1ton

---
 rtl/nd_1ton_pkg.sv | 37 +++
 rtl/nd_fifo.sv | 52 +++++
 rtl/nd_1ton.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nd_1ton_pkg.sv
// Shared nd_1ton definitions: the hglobal NS_* macros (address/data widths,
// operator codes, on/off), plus operator and sender-state enums.
`ifndef NS_HGLOBAL_DEFS
`define NS_HGLOBAL_DEFS
`define NS_ADDRESS_SIZE 32
`define NS_DATA_SIZE 32
`define NS_ON 1'b1
`define NS_OFF 1'b0
`define NS_GT_OP 2'd0
`define NS_LT_OP 2'd1
`define NS_EQ_OP 2'd2
`define NS_TRUE_OP 2'd3
`endif

package nd_1ton_pkg;

   localparam int OP_W  = 2;
   localparam int CNT_W = 16;

   typedef enum logic [OP_W-1:0] {
      OP_GT   = `NS_GT_OP,
      OP_LT   = `NS_LT_OP,
      OP_EQ   = `NS_EQ_OP,
      OP_TRUE = `NS_TRUE_OP
   } op_e;

   typedef enum logic [1:0] {
      SND_IDLE = 2'd0,
      SND_REQ  = 2'd1,
      SND_REL  = 2'd2
   } snd_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/nd_fifo.sv
// Input buffer for nd_1ton: DEPTH entries (power of two), wrap-around pointers
// with one extra bit to tell full from empty. Read data is the current head.
module nd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // A pop in the same cycle frees the slot the push lands in.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/nd_1ton.sv
// One-to-N four-phase router: buffers rcv0 messages and sends each to the lowest
// output whose compare is true, else the last output. Stats via NS_ND_1TON_STATS_EN.
module nd_1ton
   import nd_1ton_pkg::*;
#(
   parameter int                       ASZ        = `NS_ADDRESS_SIZE,
   parameter int                       DSZ        = `NS_DATA_SIZE,
   parameter int                       NUM_OUT    = 4,
   parameter int                       FIFO_DEPTH = 4,
   parameter logic [NUM_OUT*OP_W-1:0]  OPERS      = {NUM_OUT{`NS_GT_OP}},
   parameter logic [NUM_OUT*DSZ-1:0]   REF_VALS   = '0
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_rcv0_req,
   output logic                     o_rcv0_ack,
   input  logic [ASZ-1:0]           i_rcv0_addr,
   input  logic [DSZ-1:0]           i_rcv0_dat,
   output logic [NUM_OUT-1:0]       o_snd_req,
   input  logic [NUM_OUT-1:0]       i_snd_ack,
   output logic [NUM_OUT*ASZ-1:0]   o_snd_addr,
   output logic [NUM_OUT*DSZ-1:0]   o_snd_dat,
   output logic                     o_full
`ifdef NS_ND_1TON_STATS_EN
   ,
   output logic [NUM_OUT*CNT_W-1:0] o_cnt_route,
   output logic [CNT_W-1:0]         o_cnt_dflt
`endif
);

   localparam int TW = $clog2(NUM_OUT);
   localparam int MW = ASZ + DSZ;

   if (NUM_OUT < 2 || NUM_OUT > 8) begin : g_bad_num_out
      $error("nd_1ton: NUM_OUT must be 2..8");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("nd_1ton: FIFO_DEPTH must be a power of two in 2..16");
   end

   logic               ack_q, ack_d;
   logic               push, pop;
   logic               fifo_full, fifo_empty;
   logic [MW-1:0]      head;
   logic [DSZ-1:0]     head_dat;
   logic [ASZ-1:0]     head_addr;
   logic [NUM_OUT-2:0] hit;
   logic [TW-1:0]      tgt;
   logic [NUM_OUT-1:0] idle;

   nd_fifo #(
      .WIDTH (MW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .push_i  (push),
      .wdata_i ({i_rcv0_addr, i_rcv0_dat}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_dat  = head[DSZ-1:0];
   assign head_addr = head[MW-1:DSZ];

   // The last output takes every message no earlier test claims, so its own
   // operator never changes the routing decision.
   always_comb begin
      hit = '0;
      for (int k = 0; k < NUM_OUT - 1; k++) begin
         case (op_e'(OPERS[k*OP_W +: OP_W]))
            OP_GT:   hit[k] = head_dat >  REF_VALS[k*DSZ +: DSZ];
            OP_LT:   hit[k] = head_dat <  REF_VALS[k*DSZ +: DSZ];
            OP_EQ:   hit[k] = head_dat == REF_VALS[k*DSZ +: DSZ];
            OP_TRUE: hit[k] = 1'b1;
         endcase
      end
      tgt = TW'(NUM_OUT - 1);
      for (int k = NUM_OUT - 2; k >= 0; k--) begin
         if (hit[k]) tgt = TW'(k);
      end
   end

   assign pop  = !fifo_empty && idle[tgt];
   assign push = i_rcv0_req && !ack_q && (!fifo_full || pop);

   always_comb begin
      ack_d = ack_q ? i_rcv0_req : push;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) ack_q <= 1'b0;
      else         ack_q <= ack_d;
   end

   assign o_rcv0_ack = ack_q;
   assign o_full     = fifo_full;

   // Sender FSM, one per output:
   //   SND_IDLE | free; loads the head when it targets this output
   //   SND_REQ  | o_snd_req high, waiting for ack rise
   //   SND_REL  | o_snd_req low, waiting for ack fall
   for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
      snd_state_e     state_q, state_d;
      logic [ASZ-1:0] addr_q;
      logic [DSZ-1:0] dat_q;
      logic           load;

      assign load = pop && (tgt == TW'(k));

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            SND_IDLE: if (load)          state_d = SND_REQ;
            SND_REQ:  if (i_snd_ack[k])  state_d = SND_REL;
            SND_REL:  if (!i_snd_ack[k]) state_d = SND_IDLE;
            default:                     state_d = SND_IDLE;
         endcase
      end

      always_ff @(posedge i_clk) begin
         if (i_reset) begin
            state_q <= SND_IDLE;
            addr_q  <= '0;
            dat_q   <= '0;
         end else begin
            state_q <= state_d;
            if (load) begin
               addr_q <= head_addr;
               dat_q  <= head_dat;
            end
         end
      end

      assign idle[k]                    = (state_q == SND_IDLE);
      assign o_snd_req[k]               = (state_q == SND_REQ);
      assign o_snd_addr[k*ASZ +: ASZ]   = addr_q;
      assign o_snd_dat[k*DSZ +: DSZ]    = dat_q;

`ifdef NS_ND_1TON_STATS_EN
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge i_clk) begin
         if (i_reset)                                   cnt_q <= '0;
         else if (state_q == SND_REQ && i_snd_ack[k])   cnt_q <= sat_inc(cnt_q);
      end

      assign o_cnt_route[k*CNT_W +: CNT_W] = cnt_q;
`endif
   end

`ifdef NS_ND_1TON_STATS_EN
   logic [CNT_W-1:0] dflt_q;

   always_ff @(posedge i_clk) begin
      if (i_reset)          dflt_q <= '0;
      else if (pop && !(|hit)) dflt_q <= sat_inc(dflt_q);
   end

   assign o_cnt_dflt = dflt_q;
`endif

endmodule
